round_ctrl: RTL

ROUND_CTRL -- requirements
Module: round_ctrl

---
 rtl/round_ctrl_if.sv | 24 ++
 rtl/round_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/round_ctrl_if.sv
// Player-datapath <-> round sequencer bundle; master drives the game events, slave is round_ctrl.
interface round_ctrl_if;
    logic       start;
    logic       pause;
    logic       hit;
    logic [2:0] lives;
    logic       wave_clear;
    logic       play;
    logic       player_clr;
    logic       freeze;
    logic       gameover;
    logic [3:0] wave;
    logic [1:0] state;

    modport master (
        output start, pause, hit, lives, wave_clear,
        input  play, player_clr, freeze, gameover, wave, state
    );

    modport slave (
        input  start, pause, hit, lives, wave_clear,
        output play, player_clr, freeze, gameover, wave, state
    );
endinterface

// File: rtl/round_ctrl.sv
// Round sequencer: IDLE -> RUN <-> RESPAWN, RUN -> OVER -> IDLE, with every output registered.
// Pause support (toggle on pause edge while in RUN) is compiled in with ROUND_CTRL_PAUSE_EN.
module round_ctrl #(
    parameter int RESPAWN_CYCLES = 120,
    parameter int OVER_CYCLES    = 600,
    parameter int MAX_WAVE       = 9
) (
    input  logic        dclk,
    input  logic        clr,
    round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RESPAWN = 2'd2,
        OVER    = 2'd3
    } state_e;

    localparam logic [9:0] RESPAWN_LOAD = 10'(RESPAWN_CYCLES - 1);
    localparam logic [9:0] OVER_LOAD    = 10'(OVER_CYCLES - 1);
    localparam logic [3:0] WAVE_MAX     = 4'(MAX_WAVE);

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [3:0] wave_q, wave_d;
    logic       start_q, pause_q;
    logic       paused_q, paused_d;
    logic       start_ev, pause_ev;
    logic       clr_evt;
    logic       play_q, play_d;
    logic       freeze_q, freeze_d;
    logic       gameover_q, gameover_d;
    logic       player_clr_q, player_clr_d;

    assign start_ev = bus.start & ~start_q;
    assign pause_ev = bus.pause & ~pause_q;

    always_ff @(posedge dclk) begin
        if (clr) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wave_q       <= '0;
            start_q      <= 1'b0;
            pause_q      <= 1'b0;
            play_q       <= 1'b0;
            freeze_q     <= 1'b1;
            gameover_q   <= 1'b0;
            player_clr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wave_q       <= wave_d;
            start_q      <= bus.start;
            pause_q      <= bus.pause;
            play_q       <= play_d;
            freeze_q     <= freeze_d;
            gameover_q   <= gameover_d;
            player_clr_q <= player_clr_d;
        end
    end

`ifdef ROUND_CTRL_PAUSE_EN
    always_ff @(posedge dclk) begin
        if (clr) begin
            paused_q <= 1'b0;
        end else begin
            paused_q <= paused_d;
        end
    end
`else
    logic unused_pause;
    assign paused_q     = 1'b0;
    assign unused_pause = pause_ev;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wave_d   = wave_q;
        paused_d = 1'b0;
        clr_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ev) begin
                    state_d = RUN;
                    wave_d  = 4'd1;
                    clr_evt = 1'b1;
                end
            end
            RUN: begin
`ifdef ROUND_CTRL_PAUSE_EN
                paused_d = paused_q ^ pause_ev;
`endif
                // A hit outranks a simultaneous wave_clear; a paused round ignores both.
                if (!paused_q) begin
                    if (bus.hit && (bus.lives >= 3'd2)) begin
                        state_d = RESPAWN;
                        cnt_d   = RESPAWN_LOAD;
                        clr_evt = 1'b1;
                    end else if (bus.hit || (bus.lives == 3'd0)) begin
                        state_d = OVER;
                        cnt_d   = OVER_LOAD;
                    end else if (bus.wave_clear) begin
                        if (wave_q < WAVE_MAX) begin
                            wave_d = wave_q + 4'd1;
                        end
                        clr_evt = 1'b1;
                    end
                end
                if (state_d != RUN) begin
                    paused_d = 1'b0;
                end
            end
            RESPAWN: begin
                if (cnt_q == 10'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            OVER: begin
                if (cnt_q == 10'd0) begin
                    state_d = IDLE;
                    wave_d  = 4'd0;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        play_d       = (state_d != IDLE);
        freeze_d     = (state_d != RUN) | paused_d;
        gameover_d   = (state_d == OVER);
        player_clr_d = clr_evt & ~player_clr_q;
    end

    assign bus.state      = state_q;
    assign bus.play       = play_q;
    assign bus.freeze     = freeze_q;
    assign bus.gameover   = gameover_q;
    assign bus.player_clr = player_clr_q;
    assign bus.wave       = wave_q;
endmodule
